// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD read and write cores: FSM states, bus
// direction levels and the busy-flag bit position.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EN_HI,
    HOLD,
    GAP,
    DONE
  } lcd_state_t;

  localparam logic LCD_RW_READ  = 1'b1;
  localparam logic LCD_RW_WRITE = 1'b0;
  localparam int   BF_BIT       = 7;

  // Width needed to hold the larger of the strobe length and the poll limit.
  function automatic int cnt_width(input int clk_divide, input int poll_max);
    int m;
    m = (clk_divide > poll_max) ? clk_divide : poll_max;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lcd_start_detect.sv
// Rising-edge detector for the start request. The previous level is
// registered; the pulse is high in the cycle iStart first reads 1.
module lcd_start_detect (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iStart,
  output logic rise
);

  logic start_d;

  // Remember last cycle's iStart level.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) start_d <= 1'b0;
    else         start_d <= iStart;
  end

  assign rise = iStart & ~start_d;

endmodule

// File: rtl/lcd_read_core.sv
// HD44780-style read cycles on the character LCD bus: one data/status read,
// or busy-flag polling until BF clears or the read limit is reached.
//
// state | meaning
// IDLE  | bus released, waiting for a fresh start edge
// SETUP | RW/RS settled before EN rises (address setup)
// EN_HI | EN high for CLK_Divide cycles, bus sampled on the last one
// HOLD  | EN low, RW/RS held (address hold); decide finish or repoll
// GAP   | EN-low spacing between polled reads
// DONE  | completion bookkeeping (normally folded into the HOLD exit)
module lcd_read_core
  import lcd_pkg::*;
#(
  parameter int CLK_Divide = 16,
  parameter int POLL_MAX   = 255
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iStart,
  input  logic       iRS,
  input  logic       iPoll,
  output logic [7:0] oDATA,
  output logic       oDone,
  output logic       oTimeout,
  output logic       oBusy,
  input  logic [7:0] LCD_DATA_IN,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       LCD_EN
);

  localparam int CNT_W = cnt_width(CLK_Divide, POLL_MAX);
  localparam logic [CNT_W-1:0] TMR_LOAD = CNT_W'(CLK_Divide - 1);
  localparam logic [CNT_W-1:0] POLL_LIM = CNT_W'(POLL_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  lcd_state_t       state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] poll_cnt;
  logic             poll_mode;
  logic             accept;

  lcd_start_detect u_start_detect (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iStart (iStart),
    .rise   (accept)
  );

  // Read sequencer; every output is a register so the bus sees no glitches.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state     <= IDLE;
      timer     <= '0;
      poll_cnt  <= '0;
      poll_mode <= 1'b0;
      oDATA     <= 8'h00;
      oDone     <= 1'b0;
      oTimeout  <= 1'b0;
      oBusy     <= 1'b0;
      LCD_RW    <= LCD_RW_WRITE;
      LCD_RS    <= 1'b0;
      LCD_EN    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            LCD_RS    <= iRS & ~iPoll;
            poll_mode <= iPoll;
            oDone     <= 1'b0;
            oTimeout  <= 1'b0;
            oBusy     <= 1'b1;
            LCD_RW    <= LCD_RW_READ;
            poll_cnt  <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          LCD_EN <= 1'b1;
          timer  <= TMR_LOAD;
          state  <= EN_HI;
        end
        EN_HI: begin
          if (timer == '0) begin
            oDATA  <= LCD_DATA_IN;
            LCD_EN <= 1'b0;
            if (poll_cnt < POLL_LIM) poll_cnt <= poll_cnt + CNT_ONE;
            state  <= HOLD;
          end else begin
            timer <= timer - CNT_ONE;
          end
        end
        HOLD: begin
          if (poll_mode && oDATA[BF_BIT] && (poll_cnt < POLL_LIM)) begin
            timer <= TMR_LOAD;
            state <= GAP;
          end else begin
            // Completion happens on this same edge; DONE is not visited.
            if (poll_mode && oDATA[BF_BIT]) oTimeout <= 1'b1;
            oDone  <= 1'b1;
            oBusy  <= 1'b0;
            LCD_RW <= LCD_RW_WRITE;
            LCD_RS <= 1'b0;
            state  <= IDLE;
          end
        end
        GAP: begin
          if (timer == '0) state <= SETUP;
          else             timer <= timer - CNT_ONE;
        end
        DONE: begin
          oDone  <= 1'b1;
          oBusy  <= 1'b0;
          LCD_RW <= LCD_RW_WRITE;
          LCD_RS <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_read_core.sv
// Scoreboard bench for lcd_read_core: stimulus pushes the expected result of
// each read into a queue, an independent monitor pops it at oDone and also
// checks strobe width, EN-low spacing and completion latency.
module tb_lcd_read_core;
  import lcd_pkg::*;

  localparam int CD = 4;
  localparam int PM = 3;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic       iStart = 1'b0;
  logic       iRS = 1'b0;
  logic       iPoll = 1'b0;
  logic [7:0] LCD_DATA_IN = 8'h00;
  logic [7:0] oDATA;
  logic       oDone, oTimeout, oBusy, LCD_RW, LCD_RS, LCD_EN;

  lcd_read_core #(.CLK_Divide(CD), .POLL_MAX(PM)) dut (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .iStart      (iStart),
    .iRS         (iRS),
    .iPoll       (iPoll),
    .oDATA       (oDATA),
    .oDone       (oDone),
    .oTimeout    (oTimeout),
    .oBusy       (oBusy),
    .LCD_DATA_IN (LCD_DATA_IN),
    .LCD_RW      (LCD_RW),
    .LCD_RS      (LCD_RS),
    .LCD_EN      (LCD_EN)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [7:0] data;
    bit         tmo;
    int         pulses;
    bit         rs;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] bus_seq [PM];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference: what the LCD protocol yields given the bytes the panel returns.
  function automatic exp_t model(input bit poll, input bit rs);
    exp_t e;
    e.rs  = poll ? 1'b0 : rs;
    e.tmo = 1'b0;
    if (!poll) begin
      e.data   = bus_seq[0];
      e.pulses = 1;
    end else begin
      e.pulses = 0;
      e.data   = 8'h00;
      for (int i = 0; i < PM; i++) begin
        e.pulses = i + 1;
        e.data   = bus_seq[i];
        if (!bus_seq[i][BF_BIT]) break;
      end
      e.tmo = e.data[BF_BIT];
    end
    return e;
  endfunction

  // Panel model: presents the next byte of bus_seq for each EN pulse.
  int bus_idx = 0;
  bit d_prev_en = 1'b0, d_prev_busy = 1'b0;
  always @(negedge iCLK) begin
    if (oBusy && !d_prev_busy) bus_idx = 0;
    if (LCD_EN && !d_prev_en) begin
      LCD_DATA_IN = bus_seq[bus_idx];
      if (bus_idx < PM - 1) bus_idx++;
    end
    d_prev_en   = LCD_EN;
    d_prev_busy = oBusy;
  end

  // Monitor.
  int   cyc = 0, t_busy = 0, pulses = 0, en_len = 0, low_len = 0;
  int   done_cnt = 0, txn_cnt = 0;
  bit   prev_busy = 1'b0, prev_en = 1'b0, prev_done = 1'b0;
  logic rs_seen = 1'b0;
  exp_t me;
  always @(negedge iCLK) begin
    cyc++;
    if (!iRST_N) begin
      pulses = 0;
      en_len = 0;
      low_len = 0;
    end else begin
      if (oBusy && !prev_busy) begin
        t_busy  = cyc;
        pulses  = 0;
        low_len = 0;
        txn_cnt++;
      end
      if (LCD_EN) begin
        if (!prev_en) begin
          pulses++;
          rs_seen = LCD_RS;
          check("rw_during_en", LCD_RW, 1);
          if (pulses > 1) check("en_low_gap_min", (low_len >= CD), 1);
          en_len  = 0;
          low_len = 0;
        end
        en_len++;
      end else begin
        if (prev_en) check("en_width", en_len, CD);
        low_len++;
      end
      if (oDone && !prev_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got completion, required none");
        end else begin
          me = exp_q.pop_front();
          check("data", oDATA, me.data);
          check("timeout", oTimeout, me.tmo);
          check("en_pulses", pulses, me.pulses);
          check("rs", rs_seen, me.rs);
          check("latency", cyc - t_busy, 2 + CD + (me.pulses - 1) * (2 * CD + 2));
          check("busy_at_done", oBusy, 0);
          check("rw_at_done", LCD_RW, 0);
          check("rs_at_done", LCD_RS, 0);
        end
      end
    end
    prev_busy = oBusy;
    prev_en   = LCD_EN;
    prev_done = oDone;
  end

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_cnt < target && k < 200) begin
      @(negedge iCLK);
      k++;
    end
    if (done_cnt < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_wait: got %0d completions, required %0d", done_cnt, target);
    end
    @(negedge iCLK);
  endtask

  // Raises iStart (left high) and checks the accept edge's effects.
  task automatic issue(input bit poll, input bit rs, input bit expect_done);
    if (expect_done) exp_q.push_back(model(poll, rs));
    iPoll  = poll;
    iRS    = rs;
    iStart = 1'b1;
    @(negedge iCLK);
    check("accept_busy", oBusy, 1);
    check("accept_done_clr", oDone, 0);
    check("accept_tmo_clr", oTimeout, 0);
    check("accept_rw", LCD_RW, 1);
    check("accept_rs", LCD_RS, poll ? 0 : rs);
  endtask

  task automatic run(input bit poll, input bit rs);
    int tgt;
    tgt = done_cnt + 1;
    issue(poll, rs, 1'b1);
    iStart = 1'b0;
    wait_done(tgt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt, base, k;
    for (int i = 0; i < PM; i++) bus_seq[i] = 8'h00;

    repeat (3) @(negedge iCLK);
    check("rst_data", oDATA, 0);
    check("rst_done", oDone, 0);
    check("rst_tmo", oTimeout, 0);
    check("rst_busy", oBusy, 0);
    check("rst_rw", LCD_RW, 0);
    check("rst_rs", LCD_RS, 0);
    check("rst_en", LCD_EN, 0);
    iRST_N = 1'b1;
    @(negedge iCLK);

    // Single data read.
    bus_seq[0] = 8'h41;
    run(1'b0, 1'b1);

    // Poll succeeding on the third read.
    bus_seq[0] = 8'h80; bus_seq[1] = 8'h80; bus_seq[2] = 8'h05;
    run(1'b1, 1'b1);

    // Poll timing out with BF stuck.
    bus_seq[0] = 8'h80; bus_seq[1] = 8'h80; bus_seq[2] = 8'h80;
    run(1'b1, 1'b0);

    // Second start edge while busy is discarded.
    bus_seq[0] = 8'h3C;
    tgt  = done_cnt + 1;
    base = txn_cnt;
    issue(1'b0, 1'b1, 1'b1);
    @(negedge iCLK);
    iStart = 1'b0;
    @(negedge iCLK);
    iStart = 1'b1;
    wait_done(tgt);
    repeat (5) @(negedge iCLK);
    check("busy_edge_txns", txn_cnt - base, 1);
    check("busy_edge_done_held", oDone, 1);
    iStart = 1'b0;
    @(negedge iCLK);
    bus_seq[0] = 8'h99;
    run(1'b0, 1'b0);

    // Held-high start gives one transaction.
    bus_seq[0] = 8'($urandom_range(0, 255)) | 8'h01;
    tgt  = done_cnt + 1;
    base = txn_cnt;
    issue(1'b0, 1'b1, 1'b1);
    repeat (49) @(negedge iCLK);
    iStart = 1'b0;
    wait_done(tgt);
    check("held_start_txns", txn_cnt - base, 1);

    // Reset during EN_HI.
    bus_seq[0] = 8'h5A;
    base = done_cnt;
    issue(1'b0, 1'b1, 1'b0);
    @(negedge iCLK);
    iStart = 1'b0;
    @(negedge iCLK);
    iRST_N = 1'b0;
    @(negedge iCLK);
    check("midrst_en", LCD_EN, 0);
    check("midrst_rw", LCD_RW, 0);
    check("midrst_busy", oBusy, 0);
    check("midrst_done", oDone, 0);
    check("midrst_data", oDATA, 0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    repeat (20) @(negedge iCLK);
    check("midrst_no_done", done_cnt - base, 0);

    // Randomized reads and polls.
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, PM);
        for (int i = 0; i < PM; i++)
          bus_seq[i] = (i < k) ? (8'($urandom_range(0, 255)) | 8'h80)
                               : (8'($urandom_range(0, 255)) & 8'h7F);
        run(1'b1, 1'($urandom_range(0, 1)));
      end else begin
        bus_seq[0] = 8'($urandom_range(0, 255));
        run(1'b0, 1'($urandom_range(0, 1)));
      end
    end

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
